// File: rtl/pipemem_io_if.sv
// Pipeline-side bus of the MEM stage: request fields from EX/MEM, load result and error flag back.
// The master is the pipeline (or bench), the slave is pipemem_io.
interface pipemem_io_if;
  logic        mwmem;
  logic        mrmem;
  logic [1:0]  msize;
  logic        msigned;
  logic [31:0] malu;
  logic [31:0] mb;
  logic [31:0] mmo;
  logic        merr;

  // No handshake: a request presented with mwmem/mrmem high is always accepted
  // in that cycle; mmo is valid the cycle after a load and holds otherwise.
  modport master (
    output mwmem, mrmem, msize, msigned, malu, mb,
    input  mmo, merr
  );

  modport slave (
    input  mwmem, mrmem, msize, msigned, malu, mb,
    output mmo, merr
  );
endinterface

// File: rtl/pipemem_io.sv
// MEM stage: byte/half/word data RAM plus a memory-mapped I/O window (malu[31]=1),
// registered load result and a sticky misalignment flag.
module pipemem_io #(
  parameter int DEPTH_WORDS = 1024,
  parameter int NUM_IN      = 2,
  parameter int NUM_OUT     = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  pipemem_io_if.slave             bus,
  input  logic [32*NUM_IN-1:0]    in_port,
  output logic [32*NUM_OUT-1:0]   out_port
);
  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [NUM_IN-1:0][31:0]  sync1_q, sync1_d, sync2_q, sync2_d;
  logic [NUM_OUT-1:0][31:0] out_q, out_d;
  logic [31:0]              mmo_q, mmo_d;
  logic                     merr_q, merr_d;

  logic          is_io, misaligned, ram_we;
  logic [5:0]    slot;
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic [3:0]    be;
  logic [31:0]   wdata, rd_word, shifted, ram_rdata, io_rdata;
  logic [15:0]   half;
  logic          unused_bits;

  assign unused_bits = ^{bus.malu, shifted[31:8]};

  always_comb begin
    is_io      = bus.malu[31];
    slot       = bus.malu[7:2];
    idx        = bus.malu[AW+1:2];
    lane       = bus.malu[1:0];
    misaligned = !is_io && ((bus.msize == 2'b01 && lane[0]) ||
                            (bus.msize[1] && lane != 2'b00));

    be    = 4'b1111;
    wdata = bus.mb;
    case (bus.msize)
      2'b00: begin
        be    = 4'b0001 << lane;
        wdata = {4{bus.mb[7:0]}};
      end
      2'b01: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wdata = {2{bus.mb[15:0]}};
      end
      default: ;
    endcase
    ram_we = bus.mwmem && !is_io && !misaligned && !reset;

    // Read-before-write: the array is read combinationally and registered into mmo.
    rd_word = mem_q[idx];
    shifted = rd_word >> {lane, 3'b000};
    half    = lane[1] ? rd_word[31:16] : rd_word[15:0];
    case (bus.msize)
      2'b00:   ram_rdata = bus.msigned ? {{24{shifted[7]}}, shifted[7:0]} : {24'b0, shifted[7:0]};
      2'b01:   ram_rdata = bus.msigned ? {{16{half[15]}}, half} : {16'b0, half};
      default: ram_rdata = rd_word;
    endcase

    io_rdata = 32'b0;
    for (int i = 0; i < NUM_IN; i++)
      if (slot == 6'(i)) io_rdata = sync2_q[i];
    if (slot == 6'h3E) io_rdata = {30'b0, merr_q, 1'b0};

    sync1_d = in_port;
    sync2_d = sync1_q;

    out_d = out_q;
    if (bus.mwmem && is_io)
      for (int i = 0; i < NUM_OUT; i++)
        if (slot == 6'(i)) out_d[i] = bus.mb;

    mmo_d = mmo_q;
    if (bus.mrmem)
      mmo_d = is_io ? io_rdata : (misaligned ? 32'b0 : ram_rdata);

    // A clear write and a misaligned access together: the set wins.
    merr_d = merr_q;
    if (bus.mwmem && is_io && slot == 6'h3F) merr_d = 1'b0;
    if ((bus.mwmem || bus.mrmem) && misaligned) merr_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      out_q   <= '0;
      mmo_q   <= '0;
      merr_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      out_q   <= out_d;
      mmo_q   <= mmo_d;
      merr_q  <= merr_d;
    end
  end

  // RAM contents survive reset; only the write enable is gated by it.
  always_ff @(posedge clock) begin
    if (ram_we)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
  end

  assign bus.mmo  = mmo_q;
  assign bus.merr = merr_q;
  assign out_port = out_q;
endmodule

// File: tb/tb_pipemem_io.sv
// Directed bench for pipemem_io with DEPTH_WORDS=16, NUM_IN=3, NUM_OUT=4.
// Expected values are hand-computed constants.
module tb_pipemem_io;
  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [95:0]  in_port = '0;
  logic [127:0] out_port;

  int checks = 0;
  int errors = 0;

  pipemem_io_if bus();

  pipemem_io #(.DEPTH_WORDS(16), .NUM_IN(3), .NUM_OUT(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus),
    .in_port  (in_port),
    .out_port (out_port)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Present one request for a single cycle; returns 1 time unit after the committing edge.
  task automatic issue(input logic we, input logic re, input logic [1:0] size,
                       input logic sgn, input logic [31:0] addr, input logic [31:0] data);
    bus.mwmem   = we;
    bus.mrmem   = re;
    bus.msize   = size;
    bus.msigned = sgn;
    bus.malu    = addr;
    bus.mb      = data;
    cyc();
    bus.mwmem = 1'b0;
    bus.mrmem = 1'b0;
  endtask

  task automatic sw(input logic [31:0] addr, input logic [31:0] data);
    issue(1'b1, 1'b0, 2'b10, 1'b0, addr, data);
  endtask

  task automatic ld(input logic [1:0] size, input logic sgn, input logic [31:0] addr);
    issue(1'b0, 1'b1, size, sgn, addr, 32'h0);
  endtask

  initial begin
    bus.mwmem = 1'b0; bus.mrmem = 1'b0; bus.msize = 2'b10;
    bus.msigned = 1'b0; bus.malu = '0; bus.mb = '0;
    cyc(); cyc();
    reset = 1'b0;

    // Preload state, then reset with a store and load in flight.
    sw(32'h10, 32'h11223344);
    sw(32'h80000000, 32'hDEADBEEF);
    issue(1'b1, 1'b0, 2'b01, 1'b0, 32'h21, 32'hBEEF);
    ld(2'b10, 1'b0, 32'h10);
    check("pre_out0", out_port[31:0], 32'hDEADBEEF);
    check("pre_merr", {31'b0, bus.merr}, 32'h1);
    check("pre_mmo", bus.mmo, 32'h11223344);
    reset = 1'b1;
    issue(1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'h99999999);
    reset = 1'b0;
    check("rst_mmo", bus.mmo, 32'h0);
    check("rst_out0", out_port[31:0], 32'h0);
    check("rst_merr", {31'b0, bus.merr}, 32'h0);
    ld(2'b10, 1'b0, 32'h10);
    check("rst_ram_kept", bus.mmo, 32'h11223344);

    // Sub-word loads and stores.
    sw(32'h10, 32'h8899AABB);
    ld(2'b00, 1'b1, 32'h11);
    check("lb", bus.mmo, 32'hFFFFFFAA);
    ld(2'b00, 1'b0, 32'h11);
    check("lbu", bus.mmo, 32'h000000AA);
    ld(2'b01, 1'b0, 32'h12);
    check("lhu", bus.mmo, 32'h00008899);
    ld(2'b01, 1'b1, 32'h12);
    check("lh", bus.mmo, 32'hFFFF8899);
    issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'hFFFFFF55);
    ld(2'b10, 1'b0, 32'h10);
    check("sb_lw", bus.mmo, 32'h5599AABB);
    issue(1'b1, 1'b0, 2'b01, 1'b0, 32'h10, 32'h0000C3D4);
    ld(2'b10, 1'b0, 32'h10);
    check("sh_lw", bus.mmo, 32'h5599C3D4);

    // Misalignment, status slot and clear slot.
    sw(32'h20, 32'hA5A5A5A5);
    issue(1'b1, 1'b0, 2'b01, 1'b0, 32'h21, 32'h1234);
    check("mis_merr", {31'b0, bus.merr}, 32'h1);
    check("mmo_hold", bus.mmo, 32'h5599C3D4);
    ld(2'b10, 1'b0, 32'h20);
    check("mis_ram", bus.mmo, 32'hA5A5A5A5);
    ld(2'b10, 1'b0, 32'h800000F8);
    check("status", bus.mmo, 32'h2);
    sw(32'h800000FC, 32'hFFFFFFFF);
    check("clear_merr", {31'b0, bus.merr}, 32'h0);
    ld(2'b10, 1'b0, 32'h22);
    check("mis_ld_mmo", bus.mmo, 32'h0);
    check("mis_ld_merr", {31'b0, bus.merr}, 32'h1);
    sw(32'h800000FC, 32'h0);
    check("clear2", {31'b0, bus.merr}, 32'h0);

    // Output ports.
    sw(32'h8000000C, 32'h1234);
    check("out3", out_port[127:96], 32'h1234);
    check("out0_keep", out_port[31:0], 32'h0);

    // Input synchroniser latency: changed after edge e-1, sampled at e.
    in_port[64 +: 32] = 32'hCAFE;
    in_port[0 +: 32]  = 32'h600D;
    cyc();
    ld(2'b10, 1'b0, 32'h80000008);
    check("in2_early", bus.mmo, 32'h0);
    ld(2'b10, 1'b0, 32'h80000008);
    check("in2", bus.mmo, 32'hCAFE);
    ld(2'b10, 1'b0, 32'h80000000);
    check("in0", bus.mmo, 32'h600D);

    // Address wrap, unmapped read and unmapped write.
    sw(32'h40, 32'h7);
    ld(2'b10, 1'b0, 32'h0);
    check("wrap", bus.mmo, 32'h7);
    ld(2'b10, 1'b0, 32'h80000080);
    check("io_unmapped", bus.mmo, 32'h0);
    sw(32'h80000024, 32'hFFFFFFFF);
    check("slot9_out", out_port[127:96], 32'h1234);
    check("slot9_out_lo", out_port[95:64] | out_port[63:32] | out_port[31:0], 32'h0);

    // Simultaneous store and load: read-before-write.
    sw(32'h8, 32'h1);
    issue(1'b1, 1'b1, 2'b10, 1'b0, 32'h8, 32'h2);
    check("rbw_old", bus.mmo, 32'h1);
    ld(2'b10, 1'b0, 32'h8);
    check("rbw_new", bus.mmo, 32'h2);
    issue(1'b1, 1'b1, 2'b10, 1'b0, 32'h80000004, 32'hABCD);
    check("rbw_io_old", bus.mmo, 32'h0);
    check("rbw_io_out1", out_port[63:32], 32'hABCD);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipemem_io.md
# pipemem_io

Parametrised memory stage for the pipelined CPU: a single-clock data RAM with byte/halfword/word access plus a memory-mapped I/O window with configurable input and output port counts. It replaces the fixed two-in/two-out MEM stage and sits between the EX/MEM pipeline register and writeback. Loads return through a registered `mmo`, which absorbs the MEM/WB register for load data. Misaligned RAM accesses are suppressed and flagged.

## Interface
- `DEPTH_WORDS`, 1024: RAM depth in 32-bit words; power of two, 16..65536; `AW = log2(DEPTH_WORDS)`.
- `NUM_IN`, 2: input ports, 1..8.
- `NUM_OUT`, 2: output ports, 1..8.

- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `mwmem`  in  1  store request this cycle.
- `mrmem`  in  1  load request this cycle.
- `msize`  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- `msigned`  in  1  1 = sign-extend sub-word loads, 0 = zero-extend.
- `malu`  in  32  byte address.
- `mb`  in  32  store data; sub-word stores use the low bits.
- `in_port`  in  32*NUM_IN  asynchronous inputs; port i is bits [32i+31:32i].
- `mmo`  out  32  load result, registered.
- `out_port`  out  32*NUM_OUT  output registers; port i is bits [32i+31:32i].
- `merr`  out  1  sticky misalignment flag.

## Operation

**Address decode**
- `malu[31]=0` selects RAM.
  - Word index is `malu[AW+1:2]`; bits above are ignored, so addresses alias modulo the RAM size.
- `malu[31]=1` selects I/O.
  - Slot is `malu[7:2]`. `malu[30:8]`, `malu[1:0]` and `msize` are ignored; I/O is always a full word.

**RAM stores** (little-endian)
- Byte: writes lane `malu[1:0]` with `mb[7:0]`.
- Half: writes lanes {`malu[1]`*2, +1} with `mb[15:0]`.
- Word: writes all four lanes with `mb`.

**RAM loads**
- Select the same lanes as stores, then extend per `msigned`.

**Misalignment** (RAM only)
- Half with `malu[0]=1`, or word with `malu[1:0]≠0`, is misaligned.
- No RAM write occurs.
- `mmo` loads 0.
- `merr` sets and holds until reset or a clear write.

**I/O reads**
- Slot i < NUM_IN: synchronised `in_port` i.
- Slot 0x3E: status = {30'b0, `merr`, 1'b0}.
- All other slots: 0.

**I/O writes**
- Slot i < NUM_OUT: `out_port` i ← `mb`.
- Slot 0x3F: clears `merr`; write data is ignored.
- All other slots: no effect.

**Other rules**
- No request (`mrmem=0`): `mmo` holds its previous value.
- `mwmem` and `mrmem` both high: the store is performed, and `mmo` returns the pre-store data (read-before-write), including for I/O slots.
- Input synchroniser: two flops per input bit, reset to 0.
- Reset:
  - `mmo`, every `out_port`, `merr` and the synchroniser flops clear to 0.
  - RAM contents are not cleared.
  - Stores presented during a reset cycle are suppressed.

## Timing
- Request presented in cycle t; `mmo` is valid throughout cycle t+1 (one-cycle load latency).
- Stores commit at the end of cycle t.
  - A load to the same address in cycle t+1 returns the new data.
  - An `out_port` update is visible from cycle t+1.
- `merr` is set at the end of cycle t and visible in cycle t+1.
  - A clear write and a misaligned access in the same cycle: the set wins.
- Input latency: an `in_port` change that meets the setup time at edge e is read by a load issued in cycle e+2 or later.
- Reset asserted mid-access: the access is discarded, and `mmo` reads 0 in the cycle after the reset edge.
- No stall or handshake: the block accepts one access every cycle.

## Test plan
- Reset with `out_port` preloaded to 0xDEADBEEF -> all outputs 0 next cycle; RAM word 4 keeps the value written before reset.
- sw 0x8899AABB @0x10, then lb @0x11 with `msigned=1` -> `mmo`=0xFFFFFFAA; lhu @0x12 -> 0x00008899; sb 0x55 @0x13, lw @0x10 -> 0x5599AABB.
- sh @0x21 -> RAM unchanged, `merr`=1 next cycle; lw of slot 0x3E -> 0x2; write slot 0x3F -> `merr`=0.
- NUM_OUT=4, NUM_IN=3:
  - sw 0x1234 to 0x8000000C -> `out_port`[3]=0x1234 next cycle.
  - `in_port`[2]=0xCAFE driven at edge e; lw 0x80000008 issued in cycle e+2 -> 0xCAFE.
- DEPTH_WORDS=16: sw 0x7 @0x40 -> lw @0x00 returns 0x7 (wrap); lw of slot 0x20 returns 0; write to slot 9 changes nothing.
- `mwmem=mrmem=1`, sw 0x2 @0x8 over 0x1 -> `mmo`=0x1, next lw @0x8 -> 0x2.
